// File: rtl/sum_ctrl_pkg.sv
// Shared definitions for the sum_sequencer keypad/adder controller:
// controller states, key codes and operand width.
package sum_ctrl_pkg;

    localparam int OPERAND_W = 12;

    localparam logic [3:0] KEY_PLUS  = 4'hA;
    localparam logic [3:0] KEY_EQUAL = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    // Largest result that may be chained into a new addition as operand A
    localparam logic [OPERAND_W-1:0] CHAIN_LIMIT = 12'd999;

    typedef enum logic [2:0] {
        ST_ENTRY_A = 3'd0,
        ST_ENTRY_B = 3'd1,
        ST_REQ     = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/digit_accumulator.sv
// Decimal operand accumulator: builds a value one digit at a time
// (value*10 + d) up to MAX_DIGITS digits. Extra digits are dropped.
// Priority: clear, then load, then digit strobe.
module digit_accumulator
    import sum_ctrl_pkg::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [OPERAND_W-1:0] i_load_value,
    input  logic [CNT_W-1:0]     i_load_count,
    input  logic                 i_digit_valid,
    input  logic [3:0]           i_digit,
    output logic [OPERAND_W-1:0] o_value,
    output logic [CNT_W-1:0]     o_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    logic [OPERAND_W-1:0] r_value;
    logic [CNT_W-1:0]     r_count;

    // Operand value and digit count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_value <= i_load_value;
            r_count <= i_load_count;
        end else if (i_digit_valid && (r_count < MAX_CNT)) begin
            r_value <= r_value * 12'd10 + OPERAND_W'(i_digit);
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_value = r_value;
    assign o_count = r_count;

endmodule

// File: rtl/sum_sequencer.sv
// Keypad-driven two-operand addition controller. Collects operand A and B
// as decimal digits, hands them to an external adder with a one-cycle
// enable, waits for the adder's result-valid and shows the result.
// Optional feature: define SUM_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles into an ERR state (left only by clear or reset).
module sum_sequencer
    import sum_ctrl_pkg::*;
#(
    parameter int MAX_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    output logic [OPERAND_W-1:0] number1,
    output logic [OPERAND_W-1:0] number2,
    output logic                 enable,
    input  logic [OPERAND_W-1:0] sum_result,
    input  logic                 sum_state,
    output logic [OPERAND_W-1:0] display_value,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 error
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [OPERAND_W-1:0] r_result;
    logic                 r_enable;
    logic                 r_busy;
    logic                 r_result_valid;
    logic                 r_error;

    logic                 w_key_digit;
    logic                 w_key_plus;
    logic                 w_key_equal;
    logic                 w_key_clear;

    logic                 w_clr_a;
    logic                 w_clr_b;
    logic                 w_load_a;
    logic [OPERAND_W-1:0] w_load_a_value;
    logic [CNT_W-1:0]     w_load_a_count;
    logic                 w_dig_a;
    logic                 w_dig_b;
    logic                 w_latch;
    logic                 w_timeout_hit;

    logic [OPERAND_W-1:0] w_value_a;
    logic [OPERAND_W-1:0] w_value_b;
    logic [CNT_W-1:0]     w_count_a;
    logic [CNT_W-1:0]     w_count_b;
    logic [OPERAND_W-1:0] w_display;

    assign w_key_digit = key_valid && is_digit(key_code);
    assign w_key_plus  = key_valid && (key_code == KEY_PLUS);
    assign w_key_equal = key_valid && (key_code == KEY_EQUAL);
    assign w_key_clear = key_valid && (key_code == KEY_CLEAR);

`ifdef SUM_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0] r_tcnt;

    // Count WAIT cycles spent without an adder response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if ((r_state == ST_WAIT) && !sum_state) begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
        end else begin
            r_tcnt <= '0;
        end
    end

    assign w_timeout_hit = (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout_hit = 1'b0;
`endif

    // Next state and operand-accumulator controls; keys are ignored in REQ/WAIT
    always_comb begin
        w_state_next   = r_state;
        w_clr_a        = 1'b0;
        w_clr_b        = 1'b0;
        w_load_a       = 1'b0;
        w_load_a_value = '0;
        w_load_a_count = '0;
        w_dig_a        = 1'b0;
        w_dig_b        = 1'b0;
        w_latch        = 1'b0;
        case (r_state)
            ST_ENTRY_A: begin
                if (w_key_clear) begin
                    w_clr_a = 1'b1;
                    w_clr_b = 1'b1;
                end else if (w_key_digit) begin
                    w_dig_a = 1'b1;
                end else if (w_key_plus) begin
                    w_clr_b      = 1'b1;
                    w_state_next = ST_ENTRY_B;
                end else begin
                    w_state_next = ST_ENTRY_A;
                end
            end
            ST_ENTRY_B: begin
                if (w_key_clear) begin
                    w_clr_a      = 1'b1;
                    w_clr_b      = 1'b1;
                    w_state_next = ST_ENTRY_A;
                end else if (w_key_digit) begin
                    w_dig_b = 1'b1;
                end else if (w_key_equal) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_ENTRY_B;
                end
            end
            ST_REQ: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (sum_state) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_DONE;
                end else if (w_timeout_hit) begin
                    w_state_next = ST_ERR;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (w_key_clear) begin
                    w_clr_a      = 1'b1;
                    w_clr_b      = 1'b1;
                    w_state_next = ST_ENTRY_A;
                end else if (w_key_digit) begin
                    w_load_a       = 1'b1;
                    w_load_a_value = OPERAND_W'(key_code);
                    w_load_a_count = CNT_W'(1);
                    w_state_next   = ST_ENTRY_A;
                end else if (w_key_plus && (r_result <= CHAIN_LIMIT)) begin
                    // Chain the result; A is treated as full so it cannot grow
                    w_load_a       = 1'b1;
                    w_load_a_value = r_result;
                    w_load_a_count = CNT_W'(MAX_DIGITS);
                    w_clr_b        = 1'b1;
                    w_state_next   = ST_ENTRY_B;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            ST_ERR: begin
                if (w_key_clear) begin
                    w_clr_a      = 1'b1;
                    w_clr_b      = 1'b1;
                    w_state_next = ST_ENTRY_A;
                end else begin
                    w_state_next = ST_ERR;
                end
            end
            default: begin
                w_state_next = ST_ENTRY_A;
            end
        endcase
    end

    // Controller state, result latch and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_ENTRY_A;
            r_result       <= '0;
            r_enable       <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            if (w_latch) begin
                r_result <= sum_result;
            end
            r_enable       <= (w_state_next == ST_REQ);
            r_busy         <= (w_state_next == ST_REQ) || (w_state_next == ST_WAIT);
            r_result_valid <= (w_state_next == ST_DONE);
`ifdef SUM_TIMEOUT_EN
            r_error        <= (w_state_next == ST_ERR);
`else
            r_error        <= 1'b0;
`endif
        end
    end

    digit_accumulator #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_acc_a (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_clr_a),
        .i_load        (w_load_a),
        .i_load_value  (w_load_a_value),
        .i_load_count  (w_load_a_count),
        .i_digit_valid (w_dig_a),
        .i_digit       (key_code),
        .o_value       (w_value_a),
        .o_count       (w_count_a)
    );

    digit_accumulator #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_acc_b (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_clr_b),
        .i_load        (1'b0),
        .i_load_value  ('0),
        .i_load_count  ('0),
        .i_digit_valid (w_dig_b),
        .i_digit       (key_code),
        .o_value       (w_value_b),
        .o_count       (w_count_b)
    );

    // Display source selected by the registered state
    always_comb begin
        w_display = '0;
        case (r_state)
            ST_ENTRY_A: w_display = w_value_a;
            ST_ENTRY_B: w_display = w_value_b;
            ST_REQ:     w_display = w_value_b;
            ST_WAIT:    w_display = w_value_b;
            ST_DONE:    w_display = r_result;
            ST_ERR:     w_display = '0;
            default:    w_display = '0;
        endcase
    end

    assign number1       = w_value_a;
    assign number2       = w_value_b;
    assign enable        = r_enable;
    assign busy          = r_busy;
    assign result_valid  = r_result_valid;
    assign error         = r_error;
    assign display_value = w_display;

endmodule

// File: tb/tb_sum_sequencer.sv
// Self-checking bench for sum_sequencer: a mode-level reference model is
// stepped on every clock and compared with the DUT each cycle, plus
// directed scenarios with hand-computed values. SUM_TIMEOUT_EN selects
// the timeout variant in both DUT and model.
module tb_sum_sequencer;

    localparam int MAXD = 3;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [11:0] number1, number2, display_value;
    logic [11:0] sum_result = 12'd0;
    logic        sum_state = 1'b0;
    logic        enable, result_valid, busy, error;

    always #5 clk = ~clk;

    sum_sequencer #(.MAX_DIGITS(MAXD), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .number1       (number1),
        .number2       (number2),
        .enable        (enable),
        .sum_result    (sum_result),
        .sum_state     (sum_state),
        .display_value (display_value),
        .result_valid  (result_valid),
        .busy          (busy),
        .error         (error)
    );

    int total = 0;
    int bad   = 0;

    // Model: mode 0=A entry, 1=B entry, 2=request, 3=waiting, 4=done, 5=error
    int m_mode = 0;
    int m_a = 0, m_b = 0, m_ca = 0, m_cb = 0, m_res = 0, m_t = 0;
    int stub_mode = 0;   // 0 normal adder, 1 never answer, 2 always assert
    int lat = 0;
    int en_cycles = 0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int model_display();
        case (m_mode)
            0:       return m_a;
            1, 2, 3: return m_b;
            4:       return m_res;
            default: return 0;
        endcase
    endfunction

    task automatic model_clear();
        m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_mode = 0;
    endtask

    // Reference model advanced on every active edge
    always @(posedge clk) begin
        if (reset) begin
            model_clear();
            m_res = 0;
            m_t = 0;
        end else begin
            case (m_mode)
                0, 1: begin
                    if (key_valid) begin
                        if (key_code <= 4'd9) begin
                            if (m_mode == 0 && m_ca < MAXD) begin
                                m_a = m_a * 10 + int'(key_code); m_ca++;
                            end else if (m_mode == 1 && m_cb < MAXD) begin
                                m_b = m_b * 10 + int'(key_code); m_cb++;
                            end
                        end else if (key_code == 4'hA && m_mode == 0) begin
                            m_b = 0; m_cb = 0; m_mode = 1;
                        end else if (key_code == 4'hB && m_mode == 1) begin
                            m_mode = 2;
                        end else if (key_code == 4'hC) begin
                            model_clear();
                        end
                    end
                end
                2: begin
                    m_mode = 3; m_t = 0;
                end
                3: begin
                    if (sum_state) begin
                        m_res = int'(sum_result); m_mode = 4;
                    end else begin
`ifdef SUM_TIMEOUT_EN
                        m_t++;
                        if (m_t == TO) m_mode = 5;
`endif
                    end
                end
                4: begin
                    if (key_valid) begin
                        if (key_code <= 4'd9) begin
                            m_a = int'(key_code); m_ca = 1; m_mode = 0;
                        end else if (key_code == 4'hA && m_res <= 999) begin
                            m_a = m_res; m_ca = MAXD; m_b = 0; m_cb = 0; m_mode = 1;
                        end else if (key_code == 4'hC) begin
                            model_clear();
                        end
                    end
                end
                default: begin
                    if (key_valid && key_code == 4'hC) model_clear();
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model
    always @(posedge clk) begin
        #1;
        total++;
        if (enable === 1'b1) en_cycles++;
        if (!(number1 === 12'(m_a) && number2 === 12'(m_b) &&
              display_value === 12'(model_display()) &&
              enable === (m_mode == 2) && busy === (m_mode == 2 || m_mode == 3) &&
              result_valid === (m_mode == 4) && error === (m_mode == 5))) begin
            bad++;
            $display("FAIL cycle t=%0t: dut n1=%0d n2=%0d disp=%0d en=%b busy=%b rv=%b err=%b expected n1=%0d n2=%0d disp=%0d mode=%0d",
                     $time, number1, number2, display_value, enable, busy, result_valid,
                     error, m_a, m_b, model_display(), m_mode);
        end
    end

    // Adder stand-in: answers a request after 0..3 WAIT cycles with A+B
    always @(negedge clk) begin
        if (m_mode == 2) lat = $urandom_range(0, 3);
        if (stub_mode == 2) begin
            sum_state = 1'b1;
            sum_result = 12'($urandom_range(0, 4095));
        end else if (stub_mode == 0 && m_mode == 3) begin
            if (lat == 0) begin
                sum_state = 1'b1;
                sum_result = 12'(m_a + m_b);
            end else begin
                lat--;
                sum_state = 1'b0;
            end
        end else if (stub_mode == 0 && m_mode != 3 && $urandom_range(0, 7) == 0) begin
            sum_state = 1'b1;
            sum_result = 12'($urandom_range(0, 4095));
        end else begin
            sum_state = 1'b0;
        end
    end

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte ch;
            ch = s[i];
            if (ch == "+")      press(4'hA);
            else if (ch == "=") press(4'hB);
            else if (ch == "C") press(4'hC);
            else                press(4'(ch - "0"));
        end
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (m_mode != 4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_reached_done"}, int'(result_valid), 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_n1", int'(number1), 0);
        chk("reset_disp", int'(display_value), 0);
        chk("reset_flags", int'({enable, busy, result_valid, error}), 0);
        reset = 1'b0;
        @(negedge clk);

        // 897 + 78 = 975
        en_cycles = 0;
        press_str("897+78=");
        wait_done("s034");
        chk("s034_n1", int'(number1), 897);
        chk("s034_n2", int'(number2), 78);
        chk("s034_disp", int'(display_value), 975);
        chk("s034_model", m_res, 975);
        chk("s034_enable_cycles", en_cycles, 1);

        // 123 + 896 = 1019, too large to chain
        press_str("C123+896=");
        wait_done("s035");
        chk("s035_disp", int'(display_value), 1019);
        press_str("+");
        chk("s035_plus_ignored_rv", int'(result_valid), 1);
        chk("s035_plus_ignored_disp", int'(display_value), 1019);
        press_str("5=");
        chk("s035_digit_restart", int'(display_value), 5);
        chk("s035_digit_rv", int'(result_valid), 0);

        // 999 + 999 = 1998, then a 4th digit is dropped
        press_str("C999+999=");
        wait_done("s036");
        chk("s036_disp", int'(display_value), 1998);
        chk("s036_model", m_res, 1998);
        press_str("1234");
        chk("s036_n1", int'(number1), 123);
        chk("s036_disp_a", int'(display_value), 123);

        // Clear mid-entry, then clear while waiting has no effect
        press_str("C45C6");
        chk("s037_disp", int'(display_value), 6);
        stub_mode = 1;
        press_str("+1=");
        @(negedge clk);
        press_str("C");
        repeat (2) @(negedge clk);
        chk("s037_busy", int'(busy), 1);
        stub_mode = 0;
        wait_done("s037");
        chk("s037_sum", int'(display_value), 7);

`ifdef SUM_TIMEOUT_EN
        // No adder answer: error after the timeout, clear recovers
        stub_mode = 1;
        press_str("C1+2=");
        repeat (16) @(negedge clk);
        chk("s038_not_yet", int'(error), 0);
        repeat (4) @(negedge clk);
        chk("s038_error", int'(error), 1);
        chk("s038_disp", int'(display_value), 0);
        stub_mode = 0;
        press_str("C");
        chk("s038_cleared", int'(error), 0);
`else
        // No adder answer: waits indefinitely, then completes
        stub_mode = 1;
        press_str("C1+2=");
        repeat (30) @(negedge clk);
        chk("s031_still_busy", int'(busy), 1);
        chk("s031_no_error", int'(error), 0);
        stub_mode = 0;
        wait_done("s031");
        chk("s031_sum", int'(display_value), 3);
`endif

        // Reset during WAIT, then a late adder answer is ignored
        stub_mode = 1;
        press_str("C2+3=");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("s039_in_reset_busy", int'(busy), 0);
        reset = 1'b0;
        stub_mode = 2;
        repeat (2) @(negedge clk);
        stub_mode = 0;
        chk("s039_flags", int'({enable, busy, result_valid, error}), 0);
        chk("s039_disp", int'(display_value), 0);
        chk("s039_n2", int'(number2), 0);
        chk("s039_model_mode", m_mode, 0);

        // Randomized keys, adder latency, stray valids and rare resets
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            key_valid = ($urandom_range(0, 2) == 0);
            key_code = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        reset = 1'b0;
        key_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
